midi_voice_allocator: RTL and testbench
=======================================

# midi_voice_allocator

Polyphonic successor to the single-note MIDI decoder. It consumes the byte stream popped from the MIDI UART receive FIFO and parses Note On, Note Off and All Notes Off messages with running status. It allocates each note to one of `NUM_VOICES` voice slots and presents per-voice period, velocity and gate to the wave-generator bank that feeds the AC97 audio path.

## Interface
Parameters:
- `NUM_VOICES`, 4: voice slots, 2..16.
- `DELAY_W`, 10: width of the per-voice period word.
- `OMNI`, 1: 1 = accept all MIDI channels; 0 = accept only `listen_ch`.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `byte_data`  in  8  MIDI byte from the FIFO.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  the block accepts a byte this cycle; a transfer occurs when valid and ready are both high.
- `listen_ch`  in  4  channel filter, used only when `OMNI`=0.
- `voice_on`  out  `NUM_VOICES`  gate per voice.
- `voice_note`  out  `NUM_VOICES`*7  note number per voice.
- `voice_vel`  out  `NUM_VOICES`*7  velocity per voice.
- `voice_delay`  out  `NUM_VOICES`*`DELAY_W`  period word per voice, taken from the note-to-period ROM.
- `steal`  out  1  one-cycle pulse when a sounding voice is reassigned.
- `all_off`  out  1  one-cycle pulse on All Notes Off.

## Operation
- Parser states:
  - IDLE: no running status.
  - D1: awaiting the first data byte.
  - D2: awaiting the second data byte.
  - APPLY: one cycle, `byte_ready`=0.
  - SKIP: discarding bytes until the next status byte.
- Status bytes 0x80–0xEF load running status and go to D1. Accepted types are 0x8n, 0x9n and 0xBn, with n matching the channel filter. Any other type, or a non-matching channel, goes to SKIP.
- Bytes 0xF8–0xFF (realtime) are accepted and ignored; state and running status are unchanged.
- Bytes 0xF0–0xF7 clear running status and go to SKIP.
- A data byte received in IDLE is discarded. A data byte received in SKIP is discarded.
- D1 latches the key. D2 latches the value and goes to APPLY. After APPLY the parser returns to D1, so running status is kept.
- A status byte arriving in D1 or D2 aborts the partial message and restarts from the new status.
- APPLY actions, in priority order:
  - 0xBn with key 123, any value: clear all `voice_on`, pulse `all_off`. Other controllers are ignored.
  - 0x8n, or 0x9n with velocity 0: release the lowest-index sounding voice with a matching note (`voice_on`←0; note, velocity and period held). No match means no action.
  - 0x9n with velocity >0, note already sounding in some voice: retrigger the lowest-index such voice, updating its velocity and setting its rank to 0.
  - Otherwise assign the lowest-index voice with `voice_on`=0. If none is free, steal the voice with rank `NUM_VOICES`-1 and pulse `steal`. The target voice gets note, velocity, period and `voice_on`=1, and its rank is set to 0.
- Age ranks:
  - Ranks form a permutation of 0..`NUM_VOICES`-1; the reset value of voice i is i.
  - On assignment or retrigger of voice v with old rank r, every voice with rank < r increments and v becomes 0.
  - A release does not change ranks.

## Timing
- Reset values: all `voice_*` outputs 0; `steal`=0, `all_off`=0; `byte_ready`=0 while `rst` is high and 1 on the first cycle after; parser in IDLE; ranks as stated above.
- Throughput: one byte per cycle, except a 1-cycle bubble (`byte_ready`=0) in APPLY.
- Latency: second data byte accepted at cycle N → APPLY at N+1 → voice outputs and pulses visible at N+2.
- Only one message is applied per APPLY, so there are no simultaneous voice updates.
- `rst` asserted mid-message discards the partial message; every state returns to its reset value on the next edge.
- `byte_valid` deasserting mid-message has no effect; the parser waits in its current state indefinitely.

## Structure
- Shared package `midi_pkg` holds:
  - status constants NOTE_OFF=4'h8, NOTE_ON=4'h9, CTRL=4'hB;
  - CC_ALL_OFF=7'd123;
  - REALTIME_MIN=8'hF8;
  - the parser state enum.
- Sub-module `midi_note_period_rom`: 128 × `DELAY_W`, combinational, indexed by the latched key. It is also reusable by the monophonic path.
- The voice table and rank logic are generate loops over `NUM_VOICES`. Lowest-index selection is a priority encoder.

## Test plan
- Reset, then 90 3C 64: voice0 on, note 0x3C, vel 0x64, `voice_delay[0]` = ROM[60]; outputs visible 2 cycles after the final byte.
- Running status 90 3C 64 40 50 43 20: voices 0, 1 and 2 hold 0x3C, 0x40 and 0x43. Then 3C 00 releases voice 0 only.
- `NUM_VOICES`=4, five note-ons 30..34: the fifth steals voice0 (the oldest), `steal` pulses once, voice0 note = 0x34.
- 90 3C 64 with F8 interleaved between every byte: same result as without F8; `byte_ready` drops only in APPLY.
- `OMNI`=0, `listen_ch`=2: 91 3C 64 ignored, 92 3C 64 allocates voice0. Then B2 7B 00 clears all gates and pulses `all_off`.
- Assert `rst` after 90 3C: no voice activates. After release, 3C 64 alone is discarded (IDLE), leaving all outputs at 0.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state type and a lowest-set-bit encoder.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [3:0] CTRL         = 4'hB;
    localparam logic [6:0] CC_ALL_OFF   = 7'd123;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    localparam logic [7:0] SYSTEM_MIN   = 8'hF0;

    typedef enum logic [2:0] {StIdle, StD1, StD2, StApply, StSkip} parse_state_e;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

endpackage

// File: rtl/midi_note_period_rom.sv
// Note number to half-period word (48 kHz samples), saturated to DELAY_W bits.
module midi_note_period_rom #(
    parameter int unsigned DELAY_W = 10
) (
    input  logic [6:0]         note,
    output logic [DELAY_W-1:0] delay
);
    localparam int unsigned MAX_DELAY = (1 << DELAY_W) - 1;

    logic [6:0]  octave;
    logic [6:0]  semitone;
    logic [11:0] base;
    logic [11:0] shifted;

    // Base row is octave 0 (note 0 = 8.18 Hz); each octave up halves the period.
    always_comb begin
        octave   = note / 7'd12;
        semitone = note % 7'd12;
        case (semitone)
            7'd0:    base = 12'd2935;
            7'd1:    base = 12'd2770;
            7'd2:    base = 12'd2615;
            7'd3:    base = 12'd2468;
            7'd4:    base = 12'd2330;
            7'd5:    base = 12'd2199;
            7'd6:    base = 12'd2075;
            7'd7:    base = 12'd1959;
            7'd8:    base = 12'd1849;
            7'd9:    base = 12'd1746;
            7'd10:   base = 12'd1648;
            default: base = 12'd1555;
        endcase
        shifted = base >> octave;
        if (32'(shifted) > MAX_DELAY) delay = DELAY_W'(MAX_DELAY);
        else                          delay = DELAY_W'(shifted);
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Running-status MIDI parser driving a polyphonic voice table with age-rank stealing.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned DELAY_W    = 10,
    parameter bit          OMNI       = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    input  logic [3:0]                    listen_ch,
    output logic [NUM_VOICES-1:0]         voice_on,
    output logic [NUM_VOICES*7-1:0]       voice_note,
    output logic [NUM_VOICES*7-1:0]       voice_vel,
    output logic [NUM_VOICES*DELAY_W-1:0] voice_delay,
    output logic                          steal,
    output logic                          all_off
);
    localparam int unsigned RW = $clog2(NUM_VOICES);

    parse_state_e state_q, state_d;
    logic [3:0] type_q, type_d;
    logic [6:0] key_q, key_d, val_q, val_d;
    logic xfer, ch_ok, accept;

    assign byte_ready = !rst && (state_q != StApply);
    assign xfer       = byte_valid && byte_ready;
    assign ch_ok      = OMNI || (byte_data[3:0] == listen_ch);
    assign accept     = ch_ok && (byte_data[7:4] == NOTE_OFF || byte_data[7:4] == NOTE_ON ||
                                  byte_data[7:4] == CTRL);

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        key_d   = key_q;
        val_d   = val_q;
        if (state_q == StApply) begin
            state_d = StD1;
        end else if (xfer && byte_data < REALTIME_MIN) begin
            if (byte_data >= SYSTEM_MIN) begin
                state_d = StSkip;
                type_d  = '0;
            end else if (byte_data[7]) begin
                type_d  = byte_data[7:4];
                state_d = accept ? StD1 : StSkip;
            end else begin
                case (state_q)
                    StD1: begin
                        key_d   = byte_data[6:0];
                        state_d = StD2;
                    end
                    StD2: begin
                        val_d   = byte_data[6:0];
                        state_d = StApply;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            type_q  <= '0;
            key_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            key_q   <= key_d;
            val_q   <= val_d;
        end
    end

    logic apply, do_all_off, is_release, is_note_on, any_match, any_free, do_steal;
    logic [NUM_VOICES-1:0] match, free, oldest;
    logic [RW-1:0] rank [NUM_VOICES];
    logic [RW-1:0] old_rank;
    logic [3:0] hit_idx, tgt_idx;
    logic [DELAY_W-1:0] rom_delay;

    midi_note_period_rom #(.DELAY_W(DELAY_W)) u_rom (
        .note  (key_q),
        .delay (rom_delay)
    );

    assign apply      = (state_q == StApply);
    assign do_all_off = apply && type_q == CTRL && key_q == CC_ALL_OFF;
    assign is_release = apply && (type_q == NOTE_OFF || (type_q == NOTE_ON && val_q == '0));
    assign is_note_on = apply && type_q == NOTE_ON && val_q != '0;
    assign any_match  = |match;
    assign any_free   = |free;
    assign do_steal   = is_note_on && !any_match && !any_free;

    always_comb begin
        hit_idx = lowest_idx(16'(match));
        if (any_match)     tgt_idx = hit_idx;
        else if (any_free) tgt_idx = lowest_idx(16'(free));
        else               tgt_idx = lowest_idx(16'(oldest));
        old_rank = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (tgt_idx == 4'(i)) old_rank = rank[i];
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        logic               on_q;
        logic [6:0]         note_q, vel_q;
        logic [DELAY_W-1:0] delay_q;
        logic [RW-1:0]      rank_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                on_q    <= 1'b0;
                note_q  <= '0;
                vel_q   <= '0;
                delay_q <= '0;
                rank_q  <= RW'(i);
            end else if (do_all_off) begin
                on_q <= 1'b0;
            end else if (is_release) begin
                if (any_match && hit_idx == 4'(i)) on_q <= 1'b0;
            end else if (is_note_on) begin
                if (tgt_idx == 4'(i)) begin
                    on_q   <= 1'b1;
                    vel_q  <= val_q;
                    rank_q <= '0;
                    // A retrigger keeps the note and period already held.
                    if (!any_match) begin
                        note_q  <= key_q;
                        delay_q <= rom_delay;
                    end
                end else if (rank_q < old_rank) begin
                    rank_q <= rank_q + 1'b1;
                end
            end
        end

        assign voice_on[i]                      = on_q;
        assign voice_note[i*7 +: 7]             = note_q;
        assign voice_vel[i*7 +: 7]              = vel_q;
        assign voice_delay[i*DELAY_W +: DELAY_W] = delay_q;
        assign rank[i]                          = rank_q;
        assign match[i]                         = on_q && (note_q == key_q);
        assign free[i]                          = !on_q;
        assign oldest[i]                        = (rank_q == RW'(NUM_VOICES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            steal   <= 1'b0;
            all_off <= 1'b0;
        end else begin
            steal   <= do_steal;
            all_off <= do_all_off;
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench: one omni instance and one channel-2-only instance.
module tb_midi_voice_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bd_a = '0, bd_b = '0;
    logic        bv_a = 1'b0, bv_b = 1'b0;
    logic        br_a, br_b;
    logic [3:0]  on_a, on_b;
    logic [27:0] note_a, note_b, vel_a, vel_b;
    logic [39:0] dly_a, dly_b;
    logic        steal_a, steal_b, alloff_a, alloff_b;

    int n_checks = 0;
    int n_fail   = 0;
    int steal_cnt = 0;

    always #5 clk = ~clk;

    midi_voice_allocator #(.NUM_VOICES(4), .DELAY_W(10), .OMNI(1'b1)) dut_omni (
        .clk(clk), .rst(rst), .byte_data(bd_a), .byte_valid(bv_a), .byte_ready(br_a),
        .listen_ch(4'd0), .voice_on(on_a), .voice_note(note_a), .voice_vel(vel_a),
        .voice_delay(dly_a), .steal(steal_a), .all_off(alloff_a)
    );

    midi_voice_allocator #(.NUM_VOICES(4), .DELAY_W(10), .OMNI(1'b0)) dut_ch (
        .clk(clk), .rst(rst), .byte_data(bd_b), .byte_valid(bv_b), .byte_ready(br_b),
        .listen_ch(4'd2), .voice_on(on_b), .voice_note(note_b), .voice_vel(vel_b),
        .voice_delay(dly_b), .steal(steal_b), .all_off(alloff_b)
    );

    always @(posedge clk) if (!rst && steal_a) steal_cnt <= steal_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? br_b : br_a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until accepted; returns 1 time unit after the transfer edge.
    task automatic send(input bit sel, input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk);
        if (sel) begin bd_b = b; bv_b = 1'b1; end
        else     begin bd_a = b; bv_a = 1'b1; end
        while (!rdy(sel) && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (k == 8) check_eq("ready_timeout", 64'(rdy(sel)), 64'd1);
        @(posedge clk);
        #1;
        bv_a = 1'b0;
        bv_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(br_a), 64'd0);
        check_eq("rst_on", 64'(on_a), 64'd0);
        check_eq("rst_note", 64'(note_a), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 64'(br_a), 64'd1);

        // Single note-on with two-cycle latency
        send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64);
        check_eq("latency_on", 64'(on_a), 64'd0);
        check_eq("apply_bubble", 64'(br_a), 64'd0);
        tick();
        check_eq("v0_on", 64'(on_a), 64'b0001);
        check_eq("v0_note", 64'(note_a[6:0]), 64'h3C);
        check_eq("v0_vel", 64'(vel_a[6:0]), 64'h64);
        check_eq("v0_delay", 64'(dly_a[9:0]), 64'd91);

        // Running status fills voices 1 and 2, then velocity-0 release of 0x3C
        send(0, 8'h40); send(0, 8'h50); send(0, 8'h43); send(0, 8'h20);
        tick();
        check_eq("run_on", 64'(on_a), 64'b0111);
        check_eq("run_notes", 64'(note_a[20:0]), 64'({7'h43, 7'h40, 7'h3C}));
        check_eq("v1_delay", 64'(dly_a[19:10]), 64'd72);
        check_eq("v2_delay", 64'(dly_a[29:20]), 64'd61);
        send(0, 8'h3C); send(0, 8'h00);
        tick();
        check_eq("release_v0", 64'(on_a), 64'b0110);
        check_eq("release_holds_note", 64'(note_a[6:0]), 64'h3C);

        // Five note-ons on four voices: oldest (voice 0) is stolen
        do_reset();
        send(0, 8'h90);
        for (int n = 0; n < 4; n++) begin
            send(0, 8'(8'h30 + n)); send(0, 8'h40);
        end
        tick();
        check_eq("full_on", 64'(on_a), 64'b1111);
        check_eq("no_steal_yet", 64'(steal_cnt), 64'd0);
        send(0, 8'h34); send(0, 8'h40);
        tick();
        check_eq("steal_pulse", 64'(steal_a), 64'd1);
        check_eq("steal_v0_note", 64'(note_a[6:0]), 64'h34);
        check_eq("steal_v0_delay", 64'(dly_a[9:0]), 64'd145);
        tick();
        check_eq("steal_one_cycle", 64'(steal_a), 64'd0);
        check_eq("steal_count", 64'(steal_cnt), 64'd1);
        // Retrigger 0x31 (voice 1) makes it youngest; next steal hits voice 2
        send(0, 8'h31); send(0, 8'h7F);
        tick();
        check_eq("retrig_vel", 64'(vel_a[13:7]), 64'h7F);
        check_eq("retrig_no_steal", 64'(steal_a), 64'd0);
        send(0, 8'h35); send(0, 8'h40);
        tick();
        check_eq("steal2_note", 64'(note_a[20:14]), 64'h35);
        check_eq("steal2_delay", 64'(dly_a[29:20]), 64'd137);
        check_eq("steal2_keeps_v1", 64'(note_a[13:7]), 64'h31);
        tick();
        check_eq("steal_count2", 64'(steal_cnt), 64'd2);

        // Realtime bytes interleaved
        do_reset();
        send(0, 8'hF8); send(0, 8'h90); send(0, 8'hF8); send(0, 8'h3C);
        send(0, 8'hF8); send(0, 8'h64);
        check_eq("rt_apply_bubble", 64'(br_a), 64'd0);
        tick();
        check_eq("rt_ready_back", 64'(br_a), 64'd1);
        check_eq("rt_on", 64'(on_a), 64'b0001);
        check_eq("rt_note", 64'(note_a[6:0]), 64'h3C);
        send(0, 8'hF8); send(0, 8'h3C); send(0, 8'h00);
        tick();
        check_eq("rt_status_kept", 64'(on_a), 64'd0);

        // Channel filter and All Notes Off
        do_reset();
        send(1, 8'h91); send(1, 8'h3C); send(1, 8'h64);
        tick(); tick();
        check_eq("ch1_ignored", 64'(on_b), 64'd0);
        send(1, 8'h92); send(1, 8'h3C); send(1, 8'h64);
        tick();
        check_eq("ch2_on", 64'(on_b), 64'b0001);
        check_eq("ch2_note", 64'(note_b[6:0]), 64'h3C);
        send(1, 8'hB2); send(1, 8'h7B); send(1, 8'h00);
        tick();
        check_eq("alloff_gates", 64'(on_b), 64'd0);
        check_eq("alloff_pulse", 64'(alloff_b), 64'd1);
        tick();
        check_eq("alloff_one_cycle", 64'(alloff_b), 64'd0);

        // Reset mid-message discards it; data bytes in IDLE are dropped
        do_reset();
        send(0, 8'h90); send(0, 8'h3C);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'h3C); send(0, 8'h64);
        tick(); tick(); tick();
        check_eq("midrst_on", 64'(on_a), 64'd0);
        check_eq("midrst_note", 64'(note_a), 64'd0);
        check_eq("midrst_vel", 64'(vel_a), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
